data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised data memory for the 16-bit processor's load/store path, with a
//  valid/ready request/response handshake, byte-lane write enables, programmable
//  wait states and out-of-range error reporting. Sits between the MEM stage and
//  the on-chip data RAM. Supports one outstanding access; the core stalls on
//  req_ready/rsp_valid.
// PARAMETERS
//  DATA_W       16   word width in bits; a multiple of 8
//  ADDR_W       16   word-address width
//  DEPTH        1024 number of words; DEPTH <= 2**ADDR_W
//  WAIT_STATES  1    extra cycles between accept and response (0..15)
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   1         request present
//  req_ready  out  1         controller can accept a request
//  req_write  in   1         1 = store, 0 = load
//  req_addr   in   ADDR_W    word address
//  req_wdata  in   DATA_W    store data
//  req_be     in   DATA_W/8  byte-lane enables for stores (bit i = bits 8i+7:8i)
//  rsp_valid  out  1         response present
//  rsp_ready  in   1         consumer accepts the response
//  rsp_rdata  out  DATA_W    load data; 0 for stores and for errors
//  rsp_err    out  1         address >= DEPTH; the access had no effect
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=IDLE, req_ready=1 on the next cycle,
//    rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are not reset.
//  - FSM states:
//    IDLE -(req_valid&req_ready)-> WAIT when WAIT_STATES>0, else EXEC.
//    WAIT -(counter==WAIT_STATES-1)-> EXEC. The counter counts up from 0.
//    EXEC (one cycle: RAM access) -> RESP.
//    RESP -(rsp_ready)-> IDLE.
//  - req_ready=1 only in IDLE. The request fields are registered at accept; the
//    inputs are don't-care afterwards.
//  - Latency: for an accept at edge T, rsp_valid rises after edge T+2+WAIT_STATES.
//    rsp_valid stays high, with rdata and err stable, until a rsp_ready handshake.
//  - Store commits in the EXEC cycle, only to lanes with req_be=1. Store with
//    be=0 -> no change, normal response.
//  - Load reads the RAM synchronously in EXEC. The returned value reflects all
//    prior committed stores (no forwarding is needed; single outstanding).
//  - addr >= DEPTH: no RAM read or write, rsp_err=1, rsp_rdata=0, same latency.
//  - rst in WAIT: the access is aborted and a pending store is NOT committed.
//    rst in EXEC: the store has already committed (same edge). rst in RESP: the
//    response is dropped.
//  - rsp_ready asserted outside RESP is ignored. A new request is accepted no
//    earlier than the cycle after the response handshake (no back-to-back overlap).
// STRUCTURE
//  - Shared package dmem_pkg: state encoding (IDLE, WAIT, EXEC, RESP) and a
//    localparam BE_W = DATA_W/8.
//  - Sub-module dmem_array: DEPTH x DATA_W RAM with a byte-lane write enable and a
//    registered read port, so it maps to block RAM.
//  - This module contains the FSM, the wait counter, the request/response
//    registers and the range check.
// TESTING
//  1. After reset: req_ready=1, rsp_valid=0. Store addr 5, data 16'hBEEF, be=2'b11,
//     then load addr 5 -> rsp_rdata 16'hBEEF, err=0, rsp_valid 3 cycles after accept.
//  2. Store addr 5, data 16'h1234, be=2'b01 over 16'hBEEF, then load addr 5 ->
//     16'hBE34.
//  3. Load addr 1024 (DEPTH=1024) -> rsp_err=1, rdata=0; addr 1023 unchanged.
//  4. Hold rsp_ready=0 for 4 cycles -> rsp_valid/rdata stable, req_ready=0; handshake
//     -> req_ready=1 on the next cycle.
//  5. WAIT_STATES=3: store addr 7, data 16'hAAAA, assert rst during WAIT -> addr 7
//     keeps its old value, req_ready=1 after reset.
//  6. WAIT_STATES=0: latency is 2 cycles. Run back-to-back store/load pairs to 10
//     random addresses and compare against a reference model.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding and
// the default lane geometry of the 16-bit load/store path.
package dmem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int BE_W       = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W single-port RAM with byte-lane write enables and a registered
// read port, written so synthesis maps it onto block RAM.
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-before-write: on a store the read port returns the old word, which the controller discards.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W / 8; i++) begin
                    if (be[i]) begin
                        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Load/store data memory controller: valid/ready request and response, byte-lane
// stores, programmable wait states and out-of-range error reporting.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | burning WAIT_STATES cycles after accept
// EXEC  | single RAM access cycle; stores commit here
// RESP  | first cycle captures RAM output, then holds rsp_valid until rsp_ready
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                in_range;
    logic                ram_en;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;

    assign in_range = 32'(addr_q) < DEPTH;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    be_d       = req_be;
                    wait_cnt_d = 4'd0;
                    state_d    = (WAIT_STATES > 0) ? WAIT : EXEC;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 4'd0;
                    state_d    = EXEC;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            EXEC: begin
                ram_en  = in_range;
                ram_we  = in_range & write_q;
                state_d = RESP;
            end
            RESP: begin
                // RAM data lands at the start of RESP; it is registered before being presented.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !in_range;
                    rsp_rdata_d = (write_q || !in_range) ? '0 : ram_rdata;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The RAM write is not gated by rst, so a store in EXEC commits even if reset hits that edge.
    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (be_q),
        .addr  (addr_q[AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
